// File: rtl/axis_relu_maxpool.sv
`default_nettype none
// ============================================================================
// Module   : axis_relu_maxpool
// Brief    : AXI-Stream ReLU with optional pairwise (1x2) signed max-pooling.
//            Single output register stage; per-packet latched configuration.
// Revision : 1.0 - initial release
// ============================================================================
module axis_relu_maxpool #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  input  logic [31:0]             cfg_control,
  output logic [31:0]             stat_pkt_count
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [KEEP_WIDTH-1:0] hold_keep_q;
  logic                  pkt_start_q;
  logic                  relu_en_q, pool_en_q;
  logic [DATA_WIDTH-1:0] m_tdata_q;
  logic                  m_tvalid_q, m_tlast_q;
  logic [KEEP_WIDTH-1:0] m_tkeep_q;
  logic [31:0]           pkt_cnt_q;

  logic                  accept;
  logic                  relu_en, pool_en;
  logic [DATA_WIDTH-1:0] relu_data;
  logic                  out_fire, hold_load;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic [KEEP_WIDTH-1:0] out_keep;
  logic                  unused_cfg_bits;

  assign unused_cfg_bits = ^cfg_control[31:2];

  // The only storage on the output path is the output register, so we can take
  // a new beat whenever that register is empty or being drained this cycle.
  assign s_axis_tready = ~rst & (~m_tvalid_q | m_axis_tready);
  assign accept        = s_axis_tvalid & s_axis_tready;

  // On the first beat of a packet the live config applies; afterwards the latch.
  assign relu_en   = pkt_start_q ? cfg_control[0] : relu_en_q;
  assign pool_en   = pkt_start_q ? cfg_control[1] : pool_en_q;
  assign relu_data = (relu_en && s_axis_tdata[DATA_WIDTH-1]) ? '0 : s_axis_tdata;

  // Pooling state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Pooling next-state: a non-last pooled beat is parked; the partner drains it.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (state_q == ST_HOLD)             state_d = ST_EMPTY;
      else if (pool_en && !s_axis_tlast)  state_d = ST_HOLD;
    end
  end

  // Output decode: what (if anything) the accepted beat produces this cycle.
  always_comb begin
    out_fire  = 1'b0;
    hold_load = 1'b0;
    out_data  = relu_data;
    out_last  = s_axis_tlast;
    out_keep  = s_axis_tkeep;
    if (accept) begin
      if (state_q == ST_HOLD) begin
        // Strict greater-than so a tie keeps the held (earlier) value.
        out_fire = 1'b1;
        out_data = ($signed(relu_data) > $signed(hold_q)) ? relu_data : hold_q;
        out_keep = hold_keep_q & s_axis_tkeep;
      end else if (!pool_en || s_axis_tlast) begin
        out_fire = 1'b1;
      end else begin
        hold_load = 1'b1;
      end
    end
  end

  // Hold register, packet-start flag and per-packet config latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q      <= '0;
      hold_keep_q <= '0;
      pkt_start_q <= 1'b1;
      relu_en_q   <= 1'b0;
      pool_en_q   <= 1'b0;
    end else if (accept) begin
      if (hold_load) begin
        hold_q      <= relu_data;
        hold_keep_q <= s_axis_tkeep;
      end
      if (pkt_start_q) begin
        relu_en_q <= cfg_control[0];
        pool_en_q <= cfg_control[1];
      end
      pkt_start_q <= s_axis_tlast;
    end
  end

  // Output register stage; holds steady while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tkeep_q  <= '0;
    end else if (out_fire) begin
      m_tvalid_q <= 1'b1;
      m_tdata_q  <= out_data;
      m_tlast_q  <= out_last;
      m_tkeep_q  <= out_keep;
    end else if (m_axis_tready) begin
      m_tvalid_q <= 1'b0;
    end
  end

  // Completed-packet counter, free-running wrap.
  always_ff @(posedge clk) begin
    if (rst)                                      pkt_cnt_q <= '0;
    else if (m_tvalid_q && m_axis_tready && m_tlast_q) pkt_cnt_q <= pkt_cnt_q + 32'd1;
  end

  assign m_axis_tdata   = m_tdata_q;
  assign m_axis_tvalid  = m_tvalid_q;
  assign m_axis_tlast   = m_tlast_q;
  assign m_axis_tkeep   = m_tkeep_q;
  assign stat_pkt_count = pkt_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_relu_maxpool.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_relu_maxpool
// Brief    : Directed self-checking bench for axis_relu_maxpool.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_relu_maxpool;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [3:0]  s_tkeep = '0;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic [3:0]  m_tkeep;
  logic [31:0] cfg = '0;
  logic [31:0] stat;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int exp_pkts = 0;

  logic [31:0] rx_d[$];
  logic        rx_l[$];
  logic [3:0]  rx_k[$];
  int          rx_t[$];

  axis_relu_maxpool #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tkeep(s_tkeep),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tkeep(m_tkeep),
    .cfg_control(cfg), .stat_pkt_count(stat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every beat that will be handshaken at the coming rising edge.
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      rx_d.push_back(m_tdata);
      rx_l.push_back(m_tlast);
      rx_k.push_back(m_tkeep);
      rx_t.push_back(cyc);
    end
  end

  task automatic clear_rx();
    rx_d.delete(); rx_l.delete(); rx_k.delete(); rx_t.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [31:0] d, input logic l, input logic [3:0] k);
    int n = 0;
    s_tdata = d; s_tlast = l; s_tkeep = k; s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      fails++;
      $display("FAIL send_timeout: s_axis_tready=%0b required 1 within 200 cycles", s_tready);
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_tvalid = 1'b0; m_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b0) begin fails++; $display("FAIL reset_tready_forced: got %0b want 0", s_tready); end
    checks++;
    if ({m_tvalid, m_tlast, m_tkeep, m_tdata} !== 38'd0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%0b last=%0b keep=%h data=%h want all 0", m_tvalid, m_tlast, m_tkeep, m_tdata);
    end
    checks++;
    if (stat !== 32'd0) begin fails++; $display("FAIL reset_stat: got %0d want 0", stat); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (s_tready !== 1'b1) begin fails++; $display("FAIL reset_release_tready: got %0b want 1", s_tready); end
    m_tready = 1'b1;
    wait_cycles(1);
  endtask

  task automatic test_passthrough();
    logic [31:0] exp_d[4];
    int t0;
    exp_d = '{32'd5, 32'd0, 32'd0, 32'd0};
    clear_rx();
    cfg = 32'h1;
    t0 = cyc;
    send_beat(32'd5, 1'b0, 4'hF);
    send_beat(32'(-3), 1'b0, 4'hF);
    send_beat(32'd0, 1'b0, 4'hF);
    send_beat(32'(-1), 1'b1, 4'h7);
    wait_cycles(3);
    exp_pkts++;
    checks++;
    if (rx_d.size() != 4) begin fails++; $display("FAIL pass_count: got %0d beats want 4", rx_d.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rx_d[i] !== exp_d[i] || rx_l[i] !== (i == 3)) begin
          fails++;
          $display("FAIL pass_beat%0d: data=%h last=%0b want data=%h last=%0b", i, rx_d[i], rx_l[i], exp_d[i], i == 3);
        end
      end
      checks++;
      if (rx_k[3] !== 4'h7) begin fails++; $display("FAIL pass_keep: got %h want 7", rx_k[3]); end
      checks++;
      if (rx_t[0] != t0 + 1 || rx_t[3] != t0 + 4) begin
        fails++;
        $display("FAIL pass_timing: first=%0d last=%0d want %0d %0d", rx_t[0], rx_t[3], t0 + 1, t0 + 4);
      end
    end
    checks++;
    if (stat !== 32'(exp_pkts)) begin fails++; $display("FAIL pass_stat: got %0d want %0d", stat, exp_pkts); end
  endtask

  task automatic test_pool();
    clear_rx();
    cfg = 32'h3;
    send_beat(32'(-7), 1'b0, 4'hF);
    send_beat(32'd2, 1'b0, 4'h3);
    send_beat(32'd9, 1'b0, 4'hC);
    send_beat(32'd4, 1'b1, 4'hF);
    wait_cycles(3);
    exp_pkts++;
    checks++;
    if (rx_d.size() != 2) begin fails++; $display("FAIL pool_count: got %0d beats want 2", rx_d.size()); end
    else begin
      checks++;
      if (rx_d[0] !== 32'd2 || rx_l[0] !== 1'b0 || rx_k[0] !== 4'h3) begin
        fails++; $display("FAIL pool_beat0: data=%h last=%0b keep=%h want 2 0 3", rx_d[0], rx_l[0], rx_k[0]);
      end
      checks++;
      if (rx_d[1] !== 32'd9 || rx_l[1] !== 1'b1 || rx_k[1] !== 4'hC) begin
        fails++; $display("FAIL pool_beat1: data=%h last=%0b keep=%h want 9 1 c", rx_d[1], rx_l[1], rx_k[1]);
      end
    end
    checks++;
    if (stat !== 32'(exp_pkts)) begin fails++; $display("FAIL pool_stat: got %0d want %0d", stat, exp_pkts); end
  endtask

  task automatic test_odd_signed();
    clear_rx();
    cfg = 32'h2;
    send_beat(32'(-5), 1'b0, 4'hF);
    send_beat(32'(-9), 1'b0, 4'hF);
    send_beat(32'(-2), 1'b1, 4'hF);
    send_beat(32'(-4), 1'b0, 4'hF);
    send_beat(32'd6, 1'b0, 4'hF);
    send_beat(32'd7, 1'b0, 4'hF);
    send_beat(32'(-1), 1'b1, 4'hF);
    wait_cycles(3);
    exp_pkts += 2;
    checks++;
    if (rx_d.size() != 4) begin fails++; $display("FAIL odd_count: got %0d beats want 4", rx_d.size()); end
    else begin
      checks++;
      if (rx_d[0] !== 32'(-5) || rx_l[0] !== 1'b0) begin
        fails++; $display("FAIL odd_beat0: data=%h last=%0b want fffffffb 0", rx_d[0], rx_l[0]);
      end
      checks++;
      if (rx_d[1] !== 32'(-2) || rx_l[1] !== 1'b1) begin
        fails++; $display("FAIL odd_tail: data=%h last=%0b want fffffffe 1", rx_d[1], rx_l[1]);
      end
      checks++;
      if (rx_d[2] !== 32'd6 || rx_d[3] !== 32'd7 || rx_l[3] !== 1'b1) begin
        fails++; $display("FAIL signed_max: got %h %h last=%0b want 6 7 last=1", rx_d[2], rx_d[3], rx_l[3]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d0;
    logic        l0;
    clear_rx();
    cfg = 32'h1;
    fork
      begin
        for (int i = 0; i < 6; i++) send_beat(32'(i + 1), i == 5, 4'hF);
      end
      begin
        int n = 0;
        while (rx_d.size() < 2 && n < 100) begin
          @(posedge clk);
          n++;
        end
        #1 m_tready = 1'b0;
        @(negedge clk);
        d0 = m_tdata; l0 = m_tlast;
        for (int c = 0; c < 5; c++) begin
          checks++;
          if (m_tdata !== d0 || m_tlast !== l0 || m_tvalid !== 1'b1 || s_tready !== 1'b0) begin
            fails++;
            $display("FAIL stall_cycle%0d: data=%h valid=%0b s_tready=%0b want data=%h valid=1 s_tready=0",
                     c, m_tdata, m_tvalid, s_tready, d0);
          end
          @(negedge clk);
        end
        @(posedge clk);
        #1 m_tready = 1'b1;
      end
    join
    wait_cycles(3);
    exp_pkts++;
    checks++;
    if (rx_d.size() != 6) begin fails++; $display("FAIL bp_count: got %0d beats want 6", rx_d.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (rx_d[i] !== 32'(i + 1) || rx_l[i] !== (i == 5)) begin
          fails++; $display("FAIL bp_beat%0d: data=%h last=%0b want %0d %0b", i, rx_d[i], rx_l[i], i + 1, i == 5);
        end
      end
    end
    checks++;
    if (stat !== 32'(exp_pkts)) begin fails++; $display("FAIL bp_stat: got %0d want %0d", stat, exp_pkts); end
  endtask

  task automatic test_cfg_change();
    clear_rx();
    cfg = 32'h3;
    send_beat(32'(-7), 1'b0, 4'hF);
    cfg = 32'h0;
    send_beat(32'd2, 1'b0, 4'hF);
    send_beat(32'd9, 1'b0, 4'hF);
    send_beat(32'd4, 1'b1, 4'hF);
    send_beat(32'(-1), 1'b0, 4'hF);
    send_beat(32'(-2), 1'b1, 4'hF);
    wait_cycles(3);
    exp_pkts += 2;
    checks++;
    if (rx_d.size() != 4) begin fails++; $display("FAIL cfg_count: got %0d beats want 4", rx_d.size()); end
    else begin
      checks++;
      if (rx_d[0] !== 32'd2 || rx_d[1] !== 32'd9 || rx_l[1] !== 1'b1) begin
        fails++; $display("FAIL cfg_latched: got %h %h last=%0b want 2 9 last=1", rx_d[0], rx_d[1], rx_l[1]);
      end
      checks++;
      if (rx_d[2] !== 32'(-1) || rx_d[3] !== 32'(-2) || rx_l[3] !== 1'b1) begin
        fails++; $display("FAIL cfg_next_pkt: got %h %h last=%0b want ffffffff fffffffe last=1", rx_d[2], rx_d[3], rx_l[3]);
      end
    end
    checks++;
    if (stat !== 32'(exp_pkts)) begin fails++; $display("FAIL cfg_stat: got %0d want %0d", stat, exp_pkts); end
  endtask

  task automatic test_reset_hold();
    clear_rx();
    cfg = 32'h3;
    send_beat(32'd5, 1'b0, 4'hF);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_pkts = 0;
    wait_cycles(3);
    checks++;
    if (rx_d.size() != 0 || stat !== 32'd0) begin
      fails++; $display("FAIL rst_hold_discard: beats=%0d stat=%0d want 0 0", rx_d.size(), stat);
    end
    send_beat(32'd1, 1'b0, 4'hF);
    send_beat(32'd3, 1'b1, 4'hF);
    wait_cycles(3);
    exp_pkts++;
    checks++;
    if (rx_d.size() != 1) begin fails++; $display("FAIL rst_hold_count: got %0d beats want 1", rx_d.size()); end
    else begin
      checks++;
      if (rx_d[0] !== 32'd3 || rx_l[0] !== 1'b1) begin
        fails++; $display("FAIL rst_hold_beat: data=%h last=%0b want 3 1", rx_d[0], rx_l[0]);
      end
    end
    checks++;
    if (stat !== 32'(exp_pkts)) begin fails++; $display("FAIL rst_hold_stat: got %0d want %0d", stat, exp_pkts); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_pool();
    test_odd_signed();
    test_backpressure();
    test_cfg_change();
    test_reset_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
